aes_spi_master: RTL and testbench

Parallel-to-serial front end that feeds one `Encrypt` or `Decrypt` core over its `cs`/`miso`/`mosi`/`finished` serial port.
- Accepts a 128-bit block and a key via valid/ready, then streams block and key bits LSB-first into the core.
- Waits for the core to finish, then shifts the 128-bit result back out and presents it in parallel via valid/ready.
- Sits directly upstream of the core and lets system logic use the cores without bit-level sequencing.

---
 rtl/aes_spi_pkg.sv | 18 +
 rtl/aes_spi_shifter.sv | 37 +++
 rtl/aes_spi_master.sv | 136 +++++++++++++
 tb/tb_aes_spi_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES core serial front end.
// No logic; sizes and FSM encoding only.
package aes_spi_pkg;
    localparam int BLOCK_BITS      = 128;
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int CNT_BITS        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP_TX,
        S_TX_DATA,
        S_TX_KEY,
        S_WAIT,
        S_SETUP_RX,
        S_RX,
        S_HOLD
    } spi_state_t;
endpackage

// File: rtl/aes_spi_shifter.sv
// LSB-first shift register: parallel load, serial in at the MSB, serial out at bit 0.
// Latency: one cycle per shift; load wins over shift.
// Backpressure: none, the owner decides when to load or shift.
module aes_spi_shifter #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic         ser_o,
    output logic [W-1:0] par_o
);
    logic [W-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_dat_i;
        end else if (shift_i) begin
            sh_d = {ser_i, sh_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_o = sh_q[0];
    assign par_o = sh_q;
endmodule

// File: rtl/aes_spi_master.sv
// Parallel-to-serial front end for one AES Encrypt/Decrypt core (cs/miso/mosi/finished).
// Latency: 1 + 128 + KEY_BITS + W + 1 + 128 cycles from accept to out_valid (W = 1..TIMEOUT).
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int NK      = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_BITS-1:0] in_data,
    input  logic [32*NK-1:0]      in_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_BITS-1:0] out_data,
    output logic                  out_err,
    output logic                  busy,
    output logic                  core_cs,
    output logic                  core_miso,
    input  logic                  core_mosi,
    input  logic                  core_finished
);
    localparam int KEY_BITS = 32 * NK;
    localparam int TX_BITS  = BLOCK_BITS + KEY_BITS;
    localparam int WCW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    spi_state_t            state_q, state_d;
    logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;
    logic                  accept, tx_shift, rx_shift, tx_ser;
    logic                  unused_rx_ser;
    logic [TX_BITS-1:0]    unused_tx_par;
    logic [BLOCK_BITS-1:0] rx_par;

    assign accept   = in_valid && (state_q == S_IDLE);
    assign tx_shift = (state_q == S_TX_DATA) || (state_q == S_TX_KEY);
    assign rx_shift = (state_q == S_RX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (in_valid) state_d = S_SETUP_TX;
            S_SETUP_TX: state_d = S_TX_DATA;
            S_TX_DATA:  if (bit_cnt_q == CNT_BITS'(BLOCK_BITS - 1)) state_d = S_TX_KEY;
            S_TX_KEY:   if (bit_cnt_q == CNT_BITS'(KEY_BITS - 1)) state_d = S_WAIT;
            S_WAIT:     if (core_finished || (wait_cnt_q == WCW'(TIMEOUT - 1))) state_d = S_SETUP_RX;
            S_SETUP_RX: state_d = S_RX;
            S_RX:       if (bit_cnt_q == CNT_BITS'(BLOCK_BITS - 1)) state_d = S_HOLD;
            S_HOLD:     if (out_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_cs   = 1'b0;
        core_miso = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_SETUP_TX, S_SETUP_RX, S_RX: core_cs = 1'b1;
            S_TX_DATA, S_TX_KEY: begin
                core_cs   = 1'b1;
                core_miso = tx_ser;
            end
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Counters restart on every state change; a finish on the last wait cycle is not an error.
    always_comb begin
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        err_d      = err_q;
        if (state_d == state_q) begin
            if (state_q inside {S_TX_DATA, S_TX_KEY, S_RX}) bit_cnt_d = bit_cnt_q + 1'b1;
            if (state_q == S_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((state_q == S_WAIT) && (state_d == S_SETUP_RX) && !core_finished) err_d = 1'b1;
        if ((state_q == S_HOLD) && out_ready) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    aes_spi_shifter #(.W(TX_BITS)) u_tx (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (accept),
        .load_dat_i ({in_key, in_data}),
        .shift_i    (tx_shift),
        .ser_i      (1'b0),
        .ser_o      (tx_ser),
        .par_o      (unused_tx_par)
    );

    aes_spi_shifter #(.W(BLOCK_BITS)) u_rx (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (1'b0),
        .load_dat_i ('0),
        .shift_i    (rx_shift),
        .ser_i      (core_mosi),
        .ser_o      (unused_rx_ser),
        .par_o      (rx_par)
    );

    assign out_data = rx_par;
    assign out_err  = err_q;
endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master with a behavioural serial core and a result scoreboard.
module tb_aes_spi_master;
    localparam int KB      = 256;
    localparam int TIMEOUT = 64;
    localparam bit ENC = 1'b0;
    localparam bit DEC = 1'b1;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [255:0] K2  = 256'h1234567898765432123456789876543223456789876543212345678987654321;
    localparam logic [127:0] CT2 = 128'h47873078fce1892d61952dfdfbef037f;

    typedef struct {
        logic [127:0] dat;
        logic         err;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [255:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_err;
    logic         busy;
    logic         core_cs;
    logic         core_miso;
    logic         core_mosi = 1'b0;
    logic         core_finished = 1'b0;

    int checks = 0;
    int failures = 0;
    sb_t sb_q[$];

    // Core model configuration and state
    bit           m_mode = ENC;
    int           m_fin = 1;
    bit           m_nofin = 1'b0;
    int           exp_wait = 1;
    logic [127:0] exp_tx_dat = '0;
    logic [255:0] exp_tx_key = '0;
    int           phase = 0;
    int           burst = 0;
    int           wc = 0;
    logic [127:0] m_dat = '0;
    logic [255:0] m_key = '0;
    logic [127:0] m_result = '0;

    aes_spi_master #(.NK(8), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_key        (in_key),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err),
        .busy          (busy),
        .core_cs       (core_cs),
        .core_miso     (core_miso),
        .core_mosi     (core_mosi),
        .core_finished (core_finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] core_fn(input bit mode, input logic [127:0] d, input logic [255:0] k);
        if (!mode && d == PT1 && k == K1) return CT1;
        if (mode && d == CT1 && k == K1)  return PT1;
        if (!mode && d == PT2 && k == K2) return CT2;
        if (mode && d == CT2 && k == K2)  return PT2;
        return d ^ k[127:0] ^ k[255:128];
    endfunction

    // Behavioural core: samples miso and drives mosi/finished on falling edges.
    always @(negedge clk) begin
        if (!rst) begin
            phase = 0;
            burst = 0;
            wc = 0;
            core_finished = 1'b0;
            core_mosi = 1'b0;
        end else if (core_cs) begin
            if (phase == 1) begin
                check("wait_len", wc, exp_wait);
                phase = 2;
                burst = 0;
                core_finished = 1'b0;
            end
            burst++;
            if (phase == 0) begin
                if (burst == 1) check("miso_setup", core_miso, 0);
                else if (burst <= 129) m_dat[burst-2] = core_miso;
                else if (burst <= 129 + KB) m_key[burst-130] = core_miso;
            end else begin
                core_mosi = (burst >= 2 && burst <= 129) ? m_result[burst-2] : 1'b0;
            end
        end else begin
            core_mosi = 1'b0;
            if (phase == 0 && burst > 0) begin
                check("tx_cs_len", burst, 129 + KB);
                check("tx_data_bits", m_dat, exp_tx_dat);
                check("tx_key_bits", m_key, exp_tx_key);
                m_result = core_fn(m_mode, m_dat, m_key);
                phase = 1;
                wc = 0;
                burst = 0;
            end else if (phase == 2 && burst > 0) begin
                check("rx_cs_len", burst, 129);
                phase = 0;
                burst = 0;
            end
            if (phase == 1) begin
                wc++;
                if (!m_nofin && wc == m_fin) core_finished = 1'b1;
            end
        end
    end

    task automatic run_txn(input bit mode, input logic [127:0] data, input logic [255:0] key,
                           input int fin, input bit nofin, input int hold, input bit tie_ready,
                           input logic [127:0] exp_dat, input logic exp_err, input int exp_lat);
        sb_t e;
        int cyc;
        m_mode = mode;
        m_fin = fin;
        m_nofin = nofin;
        exp_wait = nofin ? TIMEOUT : fin;
        exp_tx_dat = data;
        exp_tx_key = key;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data = data;
        in_key = key;
        out_ready = tie_ready;
        e.dat = exp_dat;
        e.err = exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = ~data;
        in_key = ~key;
        check("busy_after_accept", busy, 1);
        cyc = 0;
        while (!out_valid && cyc < 2000) begin
            if (cyc == 20) in_valid = 1'b1;
            if (cyc == 23) begin
                check("in_ready_busy", in_ready, 0);
                in_valid = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("out_valid_rise", out_valid, 1);
        check("latency", cyc, exp_lat);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.dat);
            check("out_err", out_err, e.err);
        end
        if (!tie_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, exp_dat);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_err", out_err, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [127:0] rd;
        logic [255:0] rk;
        #2;
        check("rst_cs", core_cs, 0);
        check("rst_miso", core_miso, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_txn(ENC, PT1, K1, 30, 1'b0, 10, 1'b0, CT1, 1'b0, 544);
        run_txn(DEC, CT1, K1, 1, 1'b0, 0, 1'b1, PT1, 1'b0, 515);
        run_txn(DEC, CT2, K2, TIMEOUT, 1'b0, 2, 1'b0, PT2, 1'b0, 578);
        run_txn(ENC, PT2, K2, 1, 1'b1, 3, 1'b0, CT2, 1'b1, 578);
        rd = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_txn(ENC, rd, rk, 5, 1'b0, 1, 1'b0, core_fn(ENC, rd, rk), 1'b0, 519);

        // Abort a transaction in the middle of the key phase.
        m_mode = ENC;
        m_fin = 10;
        m_nofin = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = PT2;
        in_key = K2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (179) @(posedge clk);
        @(negedge clk);
        check("cs_before_reset", core_cs, 1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_cs", core_cs, 0);
        check("abort_miso", core_miso, 0);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_err", out_err, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        check("abort_sb_empty", sb_q.size(), 0);
        run_txn(ENC, PT1, K1, 10, 1'b0, 1, 1'b0, CT1, 1'b0, 524);

        check("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
